// File: rtl/aes_cipher_serializer.sv
// aes_cipher_serializer
// Follows the AES encrypt pipeline. It tracks each launched block until the
// block leaves the pipeline, then captures the parallel cipher_text array into
// a small block FIFO. Blocks are emitted one byte at a time, in column-major
// order, over a valid/ready stream. A block that arrives while the FIFO is full
// is dropped, and the drop is flagged on the sticky overflow output.
// Optional feature: define AES_SER_DROP_COUNT_EN to add the drop_count output,
// which saturates at 0xFF.
module aes_cipher_serializer #(
   parameter int N       = 4,
   parameter int LATENCY = 20,
   parameter int DEPTH   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       launch,
   input  logic [7:0] cipher_text [N][N],
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       byte_last,
   output logic       overflow
`ifdef AES_SER_DROP_COUNT_EN
   ,
   output logic [7:0] drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;

   logic [LATENCY-1:0] launch_p;
   logic               tap;
   logic [7:0]         mem [DEPTH][N][N];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic [RW-1:0]      row;
   logic [RW-1:0]      col;
   logic               at_last;
   logic               full;
   logic               xfer;
   logic               pop;
   logic               push;
   logic               drop;

   assign tap = launch_p[LATENCY-1];

   // Launch tracker: delay line whose last tap marks the cycle a block's result is present
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         launch_p <= '0;
      end else begin
         launch_p[0] <= launch;
         for (int i = 1; i < LATENCY; i++)
            launch_p[i] <= launch_p[i-1];
      end
   end

   // FIFO status, handshake and head-byte selection, all taken from registered state
   always_comb begin
      at_last    = (row == RW'(N - 1)) && (col == RW'(N - 1));
      byte_valid = (count != '0);
      byte_last  = byte_valid && at_last;
      xfer       = byte_valid && byte_ready;
      pop        = xfer && at_last;
      full       = (count == CW'(DEPTH));
      // A full FIFO still accepts the block when the head leaves in the same cycle
      push       = tap && (!full || pop);
      drop       = tap && full && !pop;
      byte_out   = mem[rd_ptr][row][col];
   end

   // Block storage: capture the whole state array into the write slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < DEPTH; d++)
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++)
                  mem[d][r][c] <= 8'h00;
      end else if (push) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               mem[wr_ptr][r][c] <= cipher_text[r][c];
      end
   end

   // FIFO pointers and occupancy; the pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Byte index kept as (row, col); row runs fastest, giving column-major output order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (xfer) begin
         if (row == RW'(N - 1)) begin
            row <= '0;
            col <= (col == RW'(N - 1)) ? '0 : col + 1'b1;
         end else begin
            row <= row + 1'b1;
         end
      end
   end

   // Sticky drop flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
   end

`ifdef AES_SER_DROP_COUNT_EN
   // Saturating count of dropped blocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_count <= 8'h00;
      else if (drop && (drop_count != 8'hFF))
         drop_count <= drop_count + 8'h01;
   end
`endif

endmodule

// File: doc/aes_cipher_serializer.md
# aes_cipher_serializer

Downstream stage of the 128-bit AES encrypt pipeline: it tracks when each launched block emerges from the pipeline and captures the parallel `cipher_text` state array at that moment. It buffers the captured blocks in a small block FIFO and emits them one byte at a time over a valid/ready stream. It is the only point where pipeline output becomes flow-controlled, so it also detects and flags blocks lost to overflow.

## Interface
Parameters:
- `N`, 4: state array dimension; a block is N*N bytes.
- `LATENCY`, 20: clock cycles from the launch cycle to the cycle in which `cipher_text` holds that block's result; must be ≥1.
- `DEPTH`, 2: block FIFO depth in whole blocks; power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `launch`, in, 1: a plaintext/key pair is presented to the encrypt pipeline this cycle.
- `cipher_text`, in, [7:0] [N][N]: parallel pipeline output, s[row][col].
- `byte_out`, out, 8: current output byte.
- `byte_valid`, out, 1: `byte_out` is valid.
- `byte_ready`, in, 1: sink accepts the byte this cycle.
- `byte_last`, out, 1: current byte is the final byte of a block.
- `overflow`, out, 1: sticky; a completed block was dropped.

## Operation
- **Launch tracker:** LATENCY-stage shift register of `launch`.
  - Tap high in cycle t exactly when `launch` was high in cycle t−LATENCY.
  - Tracker accepts back-to-back launches every cycle.
- **Capture:** at the clock edge ending a cycle with tap high, `cipher_text` is written into the FIFO slot at the write pointer, and the write pointer increments, wrapping at DEPTH.
- **Full-FIFO capture:**
  - If the FIFO is full and no pop occurs in the same cycle, the block is discarded and `overflow` is set.
  - If the FIFO is full and a pop occurs in the same cycle, the capture succeeds.
- **Block count:** tracked as 0..DEPTH, width clog2(DEPTH)+1.
- **Serializer:** byte index `idx` runs 0..N*N−1.
  - `byte_out` = head[idx mod N][idx / N], i.e. column-major (FIPS-197 output order).
  - `byte_valid` = FIFO non-empty.
  - `byte_last` = `byte_valid` && idx==N*N−1.
- **Transfer rule:** a transfer occurs when `byte_valid && byte_ready`.
  - Each transfer increments `idx`.
  - On the transfer with `byte_last` high, `idx` returns to 0, the head block is popped and the read pointer wraps at DEPTH.
- **Sink hold:** the sink may hold `byte_ready` low indefinitely. `byte_out`, `byte_valid` and `byte_last` then stay stable.
- **Combinational paths:** no path from `byte_ready` to `byte_valid` or `byte_out`. Outputs depend only on registered state.
- **Reset:** asynchronous, takes effect immediately regardless of activity.
  - Clears the tracker, pointers, count, `idx` and `overflow`.
  - Outputs: `byte_valid`=0, `byte_last`=0, `overflow`=0, `byte_out`=0x00 (FIFO storage reset to zero).
  - Blocks in flight or partially emitted are lost. No block is emitted for launches issued before reset.

## Timing
- `launch` in cycle 0 → capture at the end of cycle LATENCY → `byte_valid`=1 with byte 0 in cycle LATENCY+1, if the FIFO was empty.
- With `byte_ready` held high, one byte per cycle. Block k completes N*N cycles after its first byte.
- Sustained throughput is one block per N*N cycles. Launches arriving faster fill the FIFO, then overflow.
- `overflow` rises in the cycle after the dropped capture edge and stays high until `rst`.

## Configuration
- `AES_SER_DROP_COUNT_EN`
- **Defined:** adds an output port `drop_count`, out, 8.
  - Saturating count of dropped blocks; saturates at 0xFF.
  - Increments in the same cycle `overflow` is set and on every later drop.
  - Reset to 0.
- **Undefined:** port absent. Only sticky `overflow` reports drops, with identical behaviour.

## Test plan
- **Reset:** assert `rst` mid-cycle with the FIFO holding 2 blocks → outputs immediately `byte_valid`=0, `overflow`=0, `byte_out`=0x00. No bytes are emitted afterwards without a new launch.
- **Single block:**
  - Stimulus: `launch` in cycle 0; `cipher_text` = 69c4e0d86a7b0430d8cdb78070b4c55a (column-major) in cycle 20; `byte_ready`=1.
  - Response: bytes 0x69,0xc4,…,0x5a in cycles 21–36.
  - `byte_last` high only in cycle 36 with 0x5a.
- **Backpressure:** same block; `byte_ready` low for cycles 23–27.
  - Byte 0xe0 held stable with `byte_valid`=1 throughout.
  - Sequence completes 5 cycles later, with no byte repeated or skipped.
- **Overflow:** DEPTH=2, `byte_ready`=0, launches in cycles 0,1,2 → `overflow`=1 in cycle 23.
  - After releasing ready, exactly 32 bytes emerge: blocks from cycles 20 and 21.
  - With the macro, `drop_count`=1.
- **Full with pop:** FIFO full, and the pop of the last byte coincides with a capture edge → the captured block is stored, `overflow` stays 0, and all three blocks emerge in order.
- **Pointer wrap:** 10 launches spaced 16 cycles apart with `byte_ready`=1 → all 160 bytes are emitted in order and `overflow` stays 0.
